// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; result {rem,quo} 33 edges after accept (1 edge for /0).
// No backpressure: start_i is a level request held until ready_o, result holds while start_i stays high.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] divisor;
  logic              sign_q;
  logic              sign_r;

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W:0]   trial;
  logic              ge;
  logic [DATA_W-1:0] rem_nx;
  logic [DATA_W-1:0] quo_nx;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic              last_iter;

  // Operand magnitudes; 0x80000000 negates to itself and is then treated as unsigned.
  always_comb begin
    a_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    b_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  end

  // One restoring step: rem < divisor holds, so a non-negative trial always fits DATA_W bits.
  always_comb begin
    rem_sh = {rem, quo[DATA_W-1]};
    trial  = rem_sh - {1'b0, divisor};
    ge     = ~trial[DATA_W];
    rem_nx = ge ? trial[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quo_nx = {quo[DATA_W-2:0], ge};
  end

  always_comb begin
    quo_fix   = sign_q ? -quo : quo;
    rem_fix   = sign_r ? -rem : rem;
    last_iter = (cnt == CNT_W'(DATA_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FREE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= S_BYZERO;
            end else begin
              state   <= S_ON;
              cnt     <= '0;
              rem     <= '0;
              quo     <= a_mag;
              divisor <= b_mag;
              sign_q  <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              sign_r  <= signed_div_i & opdata1_i[DATA_W-1];
            end
          end
        end

        S_BYZERO: begin
          if (annul_i) begin
            state    <= S_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            state    <= S_END;
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end

        S_ON: begin
          if (annul_i) begin
            state    <= S_FREE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (last_iter) begin
            state    <= S_END;
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_END: begin
          if (annul_i || !start_i) begin
            state    <= S_FREE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end

        default: begin
          state    <= S_FREE;
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
